// File: rtl/misao_nibble_fetch_if.sv
// Fetch-unit bus bundle: byte-read request/response toward memory, redirect
// input from branch/jump/interrupt logic, and the nibble valid/ready stream.
interface misao_nibble_fetch_if;
  logic        mem_grant;
  logic        mem_enable_read;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        nib_valid;
  logic        nib_ready;
  logic [3:0]  nib_data;
  logic [15:0] nib_pc;

  modport master (
    input  mem_grant, mem_data_in, redirect, redirect_pc, nib_ready,
    output mem_enable_read, mem_addr, nib_valid, nib_data, nib_pc
  );

  modport slave (
    output mem_grant, mem_data_in, redirect, redirect_pc, nib_ready,
    input  mem_enable_read, mem_addr, nib_valid, nib_data, nib_pc
  );
endinterface

// File: rtl/misao_nibble_fetch.sv
// Instruction-fetch front end: reads bytes, splits them low nibble first into a
// small FIFO, and hands nibbles plus their address to the decoder.
module misao_nibble_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  misao_nibble_fetch_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(2 * DEPTH + 1) + 1;

  logic [15:0]   r_fetch_pc;
  logic [15:0]   r_head_pc;
  logic          r_pending;
  logic          r_skip;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_mem [DEPTH];

  logic [CW-1:0]    w_inflight;
  logic [CW-1:0]    w_need;
  logic             w_issue;
  logic             w_resp;
  logic [CW-1:0]    w_push_n;
  logic             w_pop;
  logic [3:0]       w_nib0;
  logic [3:0]       w_nib1;
  logic [PW-1:0]    w_wr0;
  logic [PW-1:0]    w_wr1;
  logic [DEPTH-1:0] w_we0;
  logic [DEPTH-1:0] w_we1;

  function automatic logic [PW-1:0] wrap_idx(input logic [CW-1:0] v);
    logic [CW-1:0] t;
    t = (v >= CW'(DEPTH)) ? v - CW'(DEPTH) : v;
    return t[PW-1:0];
  endfunction

  // Room is reserved for everything already owed, so a response never overflows.
  assign w_inflight = r_pending ? (r_skip ? CW'(1) : CW'(2)) : '0;
  assign w_need     = r_count + w_inflight + CW'(2);
  assign w_issue    = bus.mem_grant && !bus.redirect && !rst && (w_need <= CW'(DEPTH));

  assign w_resp   = r_pending && !bus.redirect && !rst;
  assign w_push_n = w_resp ? (r_skip ? CW'(1) : CW'(2)) : '0;
  assign w_nib0   = r_skip ? bus.mem_data_in[7:4] : bus.mem_data_in[3:0];
  assign w_nib1   = bus.mem_data_in[7:4];
  assign w_pop    = (r_count != '0) && bus.nib_ready && !bus.redirect;

  assign w_wr0 = wrap_idx(CW'(r_rd_ptr) + r_count);
  assign w_wr1 = wrap_idx(CW'(r_rd_ptr) + r_count + CW'(1));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
    assign w_we0[gi] = (w_push_n != '0) && (w_wr0 == PW'(gi));
    assign w_we1[gi] = (w_push_n == CW'(2)) && (w_wr1 == PW'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_we0[i]) begin
        r_mem[i] <= w_nib0;
      end else if (w_we1[i]) begin
        r_mem[i] <= w_nib1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_head_pc  <= RESET_PC;
      r_pending  <= 1'b0;
      r_skip     <= 1'b0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (bus.redirect) begin
      r_fetch_pc <= bus.redirect_pc;
      r_head_pc  <= bus.redirect_pc;
      r_pending  <= 1'b0;
      r_skip     <= 1'b0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) begin
        r_skip     <= r_fetch_pc[0];
        r_fetch_pc <= {r_fetch_pc[15:1] + 15'd1, 1'b0};
      end
      if (w_pop) begin
        r_rd_ptr  <= wrap_idx(CW'(r_rd_ptr) + CW'(1));
        r_head_pc <= r_head_pc + 16'd1;
      end
      r_count <= r_count + w_push_n - CW'(w_pop);
    end
  end

  assign bus.mem_enable_read = w_issue;
  assign bus.mem_addr        = r_fetch_pc[15:1];
  assign bus.nib_valid       = (r_count != '0);
  assign bus.nib_data        = (r_count != '0) ? r_mem[r_rd_ptr] : 4'h0;
  assign bus.nib_pc          = r_head_pc;

endmodule
